// File: rtl/pipeline_pkg.sv
// Shared control-word layout, bubble encoding and forwarding-select codes
// for the EX/MEM/WB pipeline controller.
package pipeline_pkg;

  localparam int CTRL_W          = 8;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_STATUS     = 4;
  localparam int CTRL_ALU_OP_LO  = 5;
  localparam int CTRL_ALU_OP_HI  = 6;
  localparam int CTRL_PC_SRC     = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    PIPE_RUN,
    PIPE_STALL,
    PIPE_FLUSH
  } pipe_action_e;

endpackage

// File: rtl/forward_select.sv
// Picks the EX operand source for one ALU input by matching it against the
// destinations of the instructions in MEM and WB (MEM is newer, so it wins).
module forward_select
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_used_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_used_i) begin
      if (mem_reg_write_i && (mem_rd_i == src_i)) begin
        sel_o = FWD_EXMEM;
      end else if (wb_reg_write_i && (wb_rd_i == src_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Carries decoded control words through EX, MEM and WB, stalls on load-use
// hazards, flushes on taken branches and drives ALU forwarding selects.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [7:0]        id_ctrl,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_rn_used,
  input  logic              id_rm_used,
  input  logic              ex_branch_taken,
  output logic              pc_write_enable,
  output logic              if_id_write_enable,
  output logic              if_id_flush,
  output logic [7:0]        ex_ctrl,
  output logic [7:0]        mem_ctrl,
  output logic [7:0]        wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [7:0]        ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic [REG_AW-1:0] ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d;
  logic              ex_rn_used_q, ex_rn_used_d, ex_rm_used_q, ex_rm_used_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d, flush_count_q, flush_count_d;

  logic         hazard, branch_flush;
  pipe_action_e action;

  assign hazard = id_valid && ex_ctrl_q[CTRL_REG_WRITE] && ex_ctrl_q[CTRL_MEM_TO_REG] &&
                  (((ex_rd_q == id_rn) && id_rn_used) || ((ex_rd_q == id_rm) && id_rm_used));
  assign branch_flush = ex_ctrl_q[CTRL_PC_SRC] && ex_branch_taken;

  // A taken branch makes the ID instruction wrong-path, so it overrides any stall.
  always_comb begin
    action = PIPE_RUN;
    if (branch_flush) begin
      action = PIPE_FLUSH;
    end else if (hazard) begin
      action = PIPE_STALL;
    end
  end

  always_comb begin
    ex_ctrl_d    = CTRL_BUBBLE;
    ex_rd_d      = '0;
    ex_rn_d      = '0;
    ex_rm_d      = '0;
    ex_rn_used_d = 1'b0;
    ex_rm_used_d = 1'b0;
    if ((action == PIPE_RUN) && id_valid) begin
      ex_ctrl_d    = id_ctrl;
      ex_rd_d      = id_rd;
      ex_rn_d      = id_rn;
      ex_rm_d      = id_rm;
      ex_rn_used_d = id_rn_used;
      ex_rm_used_d = id_rm_used;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if ((action == PIPE_STALL) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if ((action == PIPE_FLUSH) && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl_q     <= CTRL_BUBBLE;
      ex_rd_q       <= '0;
      ex_rn_q       <= '0;
      ex_rm_q       <= '0;
      ex_rn_used_q  <= 1'b0;
      ex_rm_used_q  <= 1'b0;
      mem_ctrl_q    <= CTRL_BUBBLE;
      mem_rd_q      <= '0;
      wb_ctrl_q     <= CTRL_BUBBLE;
      wb_rd_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_rn_q       <= ex_rn_d;
      ex_rm_q       <= ex_rm_d;
      ex_rn_used_q  <= ex_rn_used_d;
      ex_rm_used_q  <= ex_rm_used_d;
      mem_ctrl_q    <= ex_ctrl_q;
      mem_rd_q      <= ex_rd_q;
      wb_ctrl_q     <= mem_ctrl_q;
      wb_rd_q       <= mem_rd_q;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    pc_write_enable    = (action != PIPE_STALL);
    if_id_write_enable = (action != PIPE_STALL);
    if_id_flush        = (action == PIPE_FLUSH);
  end

  forward_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i          (ex_rn_q),
    .src_used_i     (ex_rn_used_q),
    .mem_reg_write_i(mem_ctrl_q[CTRL_REG_WRITE]),
    .mem_rd_i       (mem_rd_q),
    .wb_reg_write_i (wb_ctrl_q[CTRL_REG_WRITE]),
    .wb_rd_i        (wb_rd_q),
    .sel_o          (forward_a)
  );

  forward_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i          (ex_rm_q),
    .src_used_i     (ex_rm_used_q),
    .mem_reg_write_i(mem_ctrl_q[CTRL_REG_WRITE]),
    .mem_rd_i       (mem_rd_q),
    .wb_reg_write_i (wb_ctrl_q[CTRL_REG_WRITE]),
    .wb_rd_i        (wb_rd_q),
    .sel_o          (forward_b)
  );

  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign ex_rd       = ex_rd_q;
  assign mem_rd      = mem_rd_q;
  assign wb_rd       = wb_rd_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: an instruction-level pipeline model
// is checked every cycle, alongside hand-computed checkpoints.
module tb_pipeline_controller;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              id_valid = 1'b0;
  logic [7:0]        id_ctrl = 8'h00;
  logic [REG_AW-1:0] id_rd = '0, id_rn = '0, id_rm = '0;
  logic              id_rn_used = 1'b0, id_rm_used = 1'b0;
  logic              ex_branch_taken = 1'b0;
  logic              pc_write_enable, if_id_write_enable, if_id_flush;
  logic [7:0]        ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [1:0]        forward_a, forward_b;
  logic [CNT_W-1:0]  stall_count, flush_count;

  int compared = 0;
  int mismatched = 0;

  pipeline_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .id_valid          (id_valid),
    .id_ctrl           (id_ctrl),
    .id_rd             (id_rd),
    .id_rn             (id_rn),
    .id_rm             (id_rm),
    .id_rn_used        (id_rn_used),
    .id_rm_used        (id_rm_used),
    .ex_branch_taken   (ex_branch_taken),
    .pc_write_enable   (pc_write_enable),
    .if_id_write_enable(if_id_write_enable),
    .if_id_flush       (if_id_flush),
    .ex_ctrl           (ex_ctrl),
    .mem_ctrl          (mem_ctrl),
    .wb_ctrl           (wb_ctrl),
    .ex_rd             (ex_rd),
    .mem_rd            (mem_rd),
    .wb_rd             (wb_rd),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        ctrl;
    logic [REG_AW-1:0] rd, rn, rm;
    logic              rnu, rmu;
  } instr_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe[3];
  instr_t nxtPipe[3];
  int     mStall, mFlush, nStall, nFlush;

  function automatic instr_t bubble();
    instr_t b;
    b.ctrl = 8'h00; b.rd = '0; b.rn = '0; b.rm = '0; b.rnu = 1'b0; b.rmu = 1'b0;
    return b;
  endfunction

  function automatic logic [1:0] modelFwd(logic [REG_AW-1:0] src, logic used);
    if (!used) return 2'b00;
    if (pipe[1].ctrl[0] && pipe[1].rd == src) return 2'b10;
    if (pipe[2].ctrl[0] && pipe[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
      mStall = 0;
      mFlush = 0;
    end else begin
      for (int i = 0; i < 3; i++) pipe[i] = nxtPipe[i];
      mStall = nStall;
      mFlush = nFlush;
    end
  end

  // Every cycle: predict outputs from the model, compare, then plan the next state.
  always @(negedge clk) begin
    logic   hz, br;
    instr_t idI;
    hz = id_valid && pipe[0].ctrl[0] && pipe[0].ctrl[2] &&
         ((pipe[0].rd == id_rn && id_rn_used) || (pipe[0].rd == id_rm && id_rm_used));
    br = pipe[0].ctrl[7] && ex_branch_taken;
    checkOutput("pc_we", 32'(pc_write_enable), 32'(!(hz && !br)));
    checkOutput("ifid_we", 32'(if_id_write_enable), 32'(!(hz && !br)));
    checkOutput("ifid_flush", 32'(if_id_flush), 32'(br));
    checkOutput("ex_ctrl", 32'(ex_ctrl), 32'(pipe[0].ctrl));
    checkOutput("mem_ctrl", 32'(mem_ctrl), 32'(pipe[1].ctrl));
    checkOutput("wb_ctrl", 32'(wb_ctrl), 32'(pipe[2].ctrl));
    checkOutput("ex_rd", 32'(ex_rd), 32'(pipe[0].rd));
    checkOutput("mem_rd", 32'(mem_rd), 32'(pipe[1].rd));
    checkOutput("wb_rd", 32'(wb_rd), 32'(pipe[2].rd));
    checkOutput("forward_a", 32'(forward_a), 32'(modelFwd(pipe[0].rn, pipe[0].rnu)));
    checkOutput("forward_b", 32'(forward_b), 32'(modelFwd(pipe[0].rm, pipe[0].rmu)));
    checkOutput("stall_count", 32'(stall_count), 32'(mStall));
    checkOutput("flush_count", 32'(flush_count), 32'(mFlush));
    idI.ctrl = id_ctrl; idI.rd = id_rd; idI.rn = id_rn; idI.rm = id_rm;
    idI.rnu = id_rn_used; idI.rmu = id_rm_used;
    nxtPipe[2] = pipe[1];
    nxtPipe[1] = pipe[0];
    nxtPipe[0] = (br || hz || !id_valid) ? bubble() : idI;
    nStall = (hz && !br && mStall < CNT_MAX) ? mStall + 1 : mStall;
    nFlush = (br && mFlush < CNT_MAX) ? mFlush + 1 : mFlush;
  end

  task automatic applyStimulus(input logic v, input logic [7:0] c, input int rd, input int rn,
                               input int rm, input logic rnu, input logic rmu, input logic tk);
    id_valid = v; id_ctrl = c;
    id_rd = REG_AW'(rd); id_rn = REG_AW'(rn); id_rm = REG_AW'(rm);
    id_rn_used = rnu; id_rm_used = rmu; ex_branch_taken = tk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    checkOutput("lit_reset_pc_we", 32'(pc_write_enable), 32'd1);
    checkOutput("lit_reset_ex_ctrl", 32'(ex_ctrl), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("lit_reset_stall", 32'(stall_count), 32'd0);
    checkOutput("lit_reset_flush", 32'(flush_count), 32'd0);

    // Load-use: LDRB r2 then ADD r4 reading r2
    applyStimulus(1, 8'h05, 2, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h01, 4, 2, 0, 1, 0, 0);
    checkOutput("lit_lu_pc_we", 32'(pc_write_enable), 32'd0);
    checkOutput("lit_lu_ifid_we", 32'(if_id_write_enable), 32'd0);
    tick();
    checkOutput("lit_lu_bubble", 32'(ex_ctrl), 32'd0);
    checkOutput("lit_lu_stall", 32'(stall_count), 32'd1);
    checkOutput("lit_lu_pc_we_after", 32'(pc_write_enable), 32'd1);
    tick();
    checkOutput("lit_lu_fwd_a", 32'(forward_a), 32'h1);
    checkOutput("lit_lu_ex_rd", 32'(ex_rd), 32'd4);

    // ALU forwarding from EX/MEM
    applyStimulus(1, 8'h01, 3, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h21, 5, 3, 0, 1, 0, 0);
    tick();
    checkOutput("lit_alu_fwd_a", 32'(forward_a), 32'h2);

    // MEM and WB both write r6: MEM wins
    applyStimulus(1, 8'h01, 6, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(1, 8'h41, 7, 0, 6, 0, 1, 0);
    tick();
    checkOutput("lit_prio_fwd_b", 32'(forward_b), 32'h2);
    checkOutput("lit_prio_fwd_a", 32'(forward_a), 32'h0);
    applyStimulus(1, 8'h01, 9, 6, 6, 0, 0, 0);
    tick();
    checkOutput("lit_unused_fwd_a", 32'(forward_a), 32'h0);
    checkOutput("lit_unused_fwd_b", 32'(forward_b), 32'h0);

    // Taken branch
    applyStimulus(1, 8'h80, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h01, 10, 0, 0, 0, 0, 1);
    checkOutput("lit_br_flush", 32'(if_id_flush), 32'd1);
    checkOutput("lit_br_pc_we", 32'(pc_write_enable), 32'd1);
    tick();
    checkOutput("lit_br_bubble", 32'(ex_ctrl), 32'd0);
    checkOutput("lit_br_count", 32'(flush_count), 32'd1);

    // Not-taken branch
    applyStimulus(1, 8'h80, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h01, 11, 0, 0, 0, 0, 0);
    checkOutput("lit_nt_flush", 32'(if_id_flush), 32'd0);
    tick();
    checkOutput("lit_nt_ex_ctrl", 32'(ex_ctrl), 32'h01);
    checkOutput("lit_nt_ex_rd", 32'(ex_rd), 32'd11);
    checkOutput("lit_nt_count", 32'(flush_count), 32'd1);

    // Branching load in EX with load-use in ID: flush only
    applyStimulus(1, 8'h85, 8, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h01, 12, 8, 0, 1, 0, 1);
    checkOutput("lit_both_flush", 32'(if_id_flush), 32'd1);
    checkOutput("lit_both_pc_we", 32'(pc_write_enable), 32'd1);
    tick();
    checkOutput("lit_both_stall", 32'(stall_count), 32'd1);
    checkOutput("lit_both_flushcnt", 32'(flush_count), 32'd2);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-stall
    applyStimulus(1, 8'h05, 1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8'h01, 2, 1, 0, 1, 0, 0);
    checkOutput("lit_rst_pre_stall", 32'(pc_write_enable), 32'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("lit_rst_pc_we", 32'(pc_write_enable), 32'd1);
    checkOutput("lit_rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("lit_rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    checkOutput("lit_rst_stall", 32'(stall_count), 32'd0);
    checkOutput("lit_rst_flush", 32'(flush_count), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
    tick();

    // Stall counter saturation
    for (int i = 0; i < CNT_MAX + 45; i++) begin
      applyStimulus(1, 8'h05, 1, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 8'h01, 2, 1, 0, 1, 0, 0);
      tick();
      tick();
    end
    checkOutput("lit_sat_stall", 32'(stall_count), 32'(CNT_MAX));
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
